seq_multiplier16: RTL and testbench
===================================

SEQ_MULTIPLIER16 -- requirements
Module: seq_multiplier16

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk only.
REQ-002 SHALL have port: clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: Start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port: A  input  16  unsigned multiplicand; captured when Start is accepted.
REQ-006 SHALL have port: B  input  16  unsigned multiplier; captured when Start is accepted.
REQ-007 SHALL have port: Product  output  32  unsigned result; registered.
REQ-008 SHALL have port: Busy  output  1  high while in BUSY or DONE; Start is ignored while high.
REQ-009 SHALL have port: Done  output  1  single-cycle pulse; Product is valid in that cycle.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-011 SHALL accept Start only when the state is IDLE and rst=0; acceptance at edge k latches A, sets the product register to {16'h0,B}, clears the 5-bit step counter and enters BUSY.
REQ-012 SHALL, in each BUSY cycle, perform one shift-add step:
- if P[0]=1, form {C,upper} = upper + A as a 16-bit add with carry-out C; otherwise C=0 and upper is unchanged;
- shift {C,upper,lower} right by 1 into P[31:0];
- increment the step counter.
REQ-013 SHALL leave BUSY for DONE on the edge completing step 16 (edge k+16), with the default build.
REQ-014 SHALL, in DONE, assert Done=1 for exactly one cycle with Product final, then enter IDLE on the next edge.
REQ-015 SHALL hold Product stable from DONE until the next accepted Start; Product contents during BUSY are intermediate and undefined to consumers.
REQ-016 SHALL ignore Start asserted in BUSY or DONE (no queueing); a Start held high through DONE is accepted on the first IDLE cycle.
REQ-017 SHALL give the result modulo 2^32 exactly equal to A*B for all 2^32 operand pairs; the carry out of bit 15 of the add SHALL never be dropped.
REQ-018 SHALL hold Busy=1 in BUSY and DONE, and Busy=0 in IDLE.

Reset
REQ-019 SHALL, with rst=1 at an edge, force state=IDLE, Product=32'h0, Busy=0, Done=0, step counter=0 and latched A=0, regardless of state, including mid-operation.
REQ-020 SHALL give rst priority over Start in the same cycle; Start is not accepted.
REQ-021 SHALL accept a Start in the first cycle after rst deasserts.

Configuration
REQ-022 SHALL use the macro SEQ_MUL_EARLY_TERM_EN to control early termination.
- Defined: in a BUSY step, if the remaining unprocessed multiplier bits (after this step's shift) are all zero, the step SHALL also shift P right by the remaining step count (16 minus steps done) and go to DONE on the same edge. Busy-cycle count is then msb_index(B)+1, with 1 for B=0.
- Not defined: exactly 16 BUSY cycles always.
- Product values SHALL be identical in both builds.

Verification
REQ-023 SHALL have the bench cover these directed scenarios:
- A=3, B=5, Start at edge k -> Done=1 in the cycle after edge k+16, Product=32'h0000000F, Busy=0 after edge k+17.
- A=16'hFFFF, B=16'hFFFF -> Product=32'hFFFE0001 (exercises carry-out every step).
- Start pulsed at k+3 and k+16 during an operation with A=2, B=7 -> ignored, Product=32'h0000000E, exactly one Done pulse.
- rst=1 at edge k+8 of an A=100, B=200 operation -> Product=0, Busy=0, Done=0 next cycle; a fresh Start with A=100, B=200 gives 32'h00004E20.
- SEQ_MUL_EARLY_TERM_EN defined, A=16'h1234, B=1 -> Done after edge k+1, Product=32'h00001234; with B=16'h8000 -> Done after edge k+16, Product=32'h091A0000.
- Start and rst high together, then Start held -> no acceptance while rst=1; accepted on the first cycle rst=0.

Source files
------------

// File: rtl/seq_multiplier16.sv
// 16x16 unsigned shift-add multiplier, one partial-product step per clock.
// Define SEQ_MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
//
// state  | meaning
// IDLE   | waiting for Start; Product holds the last result
// BUSY   | one shift-add step per cycle
// DONE   | Done pulse, Product final
module seq_multiplier16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [31:0] Product,
    output logic        Busy,
    output logic        Done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [15:0] a_reg;
    logic [31:0] p_reg;
    logic [4:0]  cnt;

    logic [16:0] sum;
    logic [31:0] step_p;
    logic [31:0] next_p;
    logic [4:0]  cnt_nxt;
    logic        last_step;

`ifdef SEQ_MUL_EARLY_TERM_EN
    logic        rem_zero;
`endif

    always_comb begin
        sum     = {1'b0, p_reg[31:16]};
        if (p_reg[0]) begin
            sum = {1'b0, p_reg[31:16]} + {1'b0, a_reg};
        end
        // The carry lands in bit 31 after the shift, so it is never lost.
        step_p  = {sum, p_reg[15:1]};
        cnt_nxt = cnt + 5'd1;
`ifdef SEQ_MUL_EARLY_TERM_EN
        // Unprocessed multiplier bits sit in the low (16 - steps done) bits.
        rem_zero  = ((step_p[15:0] & (16'hFFFF >> cnt_nxt)) == 16'h0000);
        next_p    = rem_zero ? (step_p >> (5'd16 - cnt_nxt)) : step_p;
        last_step = rem_zero || (cnt_nxt == 5'd16);
`else
        next_p    = step_p;
        last_step = (cnt_nxt == 5'd16);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            a_reg <= 16'h0000;
            p_reg <= 32'h0000_0000;
            cnt   <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        a_reg <= A;
                        p_reg <= {16'h0000, B};
                        cnt   <= 5'd0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    p_reg <= next_p;
                    cnt   <= cnt_nxt;
                    if (last_step) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign Product = p_reg;
    assign Busy    = (state == S_BUSY) || (state == S_DONE);
    assign Done    = (state == S_DONE);

endmodule

// File: tb/tb_seq_multiplier16.sv
// Scoreboard bench for seq_multiplier16: issued operations queue expected product and Done edge;
// a negedge monitor pops and compares on every Done pulse.
module tb_seq_multiplier16;

    logic        clk;
    logic        rst;
    logic        Start;
    logic [15:0] A;
    logic [15:0] B;
    logic [31:0] Product;
    logic        Busy;
    logic        Done;

    int total = 0;
    int bad   = 0;
    int edges = 0;
    int done_cnt = 0;

    logic [31:0] exp_p[$];
    int          exp_e[$];

    seq_multiplier16 dut (
        .clk     (clk),
        .rst     (rst),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Product (Product),
        .Busy    (Busy),
        .Done    (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int lat(input logic [15:0] b);
`ifdef SEQ_MUL_EARLY_TERM_EN
        for (int i = 15; i >= 0; i--) begin
            if (b[i]) return i + 1;
        end
        return 1;
`else
        return 16;
`endif
    endfunction

    // Monitor: every Done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (Done) begin
            done_cnt++;
            if (exp_p.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                chk("done_product", Product, exp_p.pop_front());
                chk("done_edge", edges, exp_e.pop_front());
                chk("busy_in_done", {31'd0, Busy}, 32'd1);
            end
        end
    end

    // Called just after a negedge; Start is sampled at the next posedge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit hold);
        A     = a;
        B     = b;
        Start = 1'b1;
        exp_p.push_back(32'(a) * 32'(b));
        exp_e.push_back(edges + 1 + lat(b));
        if (!hold) begin
            @(negedge clk);
            Start = 1'b0;
            chk("busy_after_accept", {31'd0, Busy}, 32'd1);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((exp_p.size() != 0 || Busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            chk({nm, "_timeout"}, 32'd1, 32'd0);
            exp_p.delete();
            exp_e.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int k;
        int d0;
        rst   = 1'b1;
        Start = 1'b0;
        A     = 16'h0;
        B     = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset_product", Product, 32'h0);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_done", {31'd0, Done}, 32'd0);
        rst = 1'b0;

        // 3*5 with explicit timing around the Done cycle
        k = edges + 1;
        issue(16'd3, 16'd5, 1'b0);
        while (edges < k + lat(16'd5)) @(negedge clk);
        chk("s1_done_pulse", {31'd0, Done}, 32'd1);
        chk("s1_product", Product, 32'h0000_000F);
        @(negedge clk);
        chk("s1_busy_idle", {31'd0, Busy}, 32'd0);
        chk("s1_done_low", {31'd0, Done}, 32'd0);
        chk("s1_product_hold", Product, 32'h0000_000F);
        wait_idle("s1");

        issue(16'hFFFF, 16'hFFFF, 1'b0);
        wait_idle("ffff");

        // Start pulses mid-operation must be ignored
        d0 = done_cnt;
        k = edges + 1;
        issue(16'd2, 16'd7, 1'b0);
        while (edges < k + 2) @(negedge clk);
        Start = 1'b1; A = 16'd9; B = 16'd9;
        @(negedge clk);
        Start = 1'b0;
        while (edges < k + 15) @(negedge clk);
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (4) @(negedge clk);
        wait_idle("ign");
        chk("ign_product", Product, 32'h0000_000E);
        chk("ign_one_done", done_cnt - d0, 32'd1);
        chk("ign_busy", {31'd0, Busy}, 32'd0);

        // Reset mid-operation, then immediate restart
        k = edges + 1;
        issue(16'd100, 16'd200, 1'b0);
        while (edges < k + 7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        void'(exp_p.pop_back());
        void'(exp_e.pop_back());
        chk("rst_mid_product", Product, 32'h0);
        chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
        chk("rst_mid_done", {31'd0, Done}, 32'd0);
        rst = 1'b0;
        issue(16'd100, 16'd200, 1'b0);
        wait_idle("rst_restart");
        chk("rst_restart_product", Product, 32'h0000_4E20);

        // Boundary vectors (early-term latency in that build)
        issue(16'h1234, 16'h0001, 1'b0);
        wait_idle("et_b1");
        issue(16'h1234, 16'h8000, 1'b0);
        wait_idle("et_b8000");
        issue(16'hABCD, 16'h0000, 1'b0);
        wait_idle("b_zero");
        issue(16'h0000, 16'hABCD, 1'b0);
        wait_idle("a_zero");
        issue(16'h00FF, 16'h0100, 1'b0);
        wait_idle("ff_x_100");
        issue(16'h8000, 16'h8000, 1'b0);
        wait_idle("msb_sq");

        // Start held through DONE: second op accepted on the first IDLE cycle
        k = edges + 1;
        issue(16'd6, 16'd7, 1'b1);
        @(negedge clk);
        A = 16'd11; B = 16'd13;
        exp_p.push_back(32'd143);
        exp_e.push_back(k + lat(16'd7) + 2 + lat(16'd13));
        while (edges < k + lat(16'd7) + 2) @(negedge clk);
        Start = 1'b0;
        wait_idle("held");

        // Start together with rst: accepted only on the first cycle rst is low
        rst = 1'b1; Start = 1'b1; A = 16'd9; B = 16'd9;
        @(negedge clk);
        chk("rst_start_busy", {31'd0, Busy}, 32'd0);
        chk("rst_start_product", Product, 32'h0);
        @(negedge clk);
        chk("rst_start_busy2", {31'd0, Busy}, 32'd0);
        rst = 1'b0;
        exp_p.push_back(32'd81);
        exp_e.push_back(edges + 1 + lat(16'd9));
        @(negedge clk);
        Start = 1'b0;
        chk("rst_release_accept", {31'd0, Busy}, 32'd1);
        wait_idle("rst_start");
        chk("queue_empty", exp_p.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
